// File: rtl/alu_mdu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_mdu : EX-stage combinational ALU with exception codes, plus a        |
// |           multi-cycle multiply/divide unit owning the HI/LO registers.   |
// |           Optional macro MDU_MADD_EN adds madd/maddu (md_op 0111/1000).  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module alu_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sa,
  input  logic [WIDTH-1:0] sb,
  input  logic [3:0]       alu_op,
  input  logic             ov_en,
  input  logic             load,
  input  logic             store,
  input  logic [3:0]       md_op,
  input  logic             md_start,
  input  logic             req,
  output logic [WIDTH-1:0] alu_out,
  output logic [4:0]       exc_code,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam int W2 = 2 * WIDTH;

  localparam logic [CW-1:0] C_MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] C_DIV_N  = CW'(DIV_CYCLES);

  localparam logic [3:0] C_ALU_ADD  = 4'd0;
  localparam logic [3:0] C_ALU_SUB  = 4'd1;
  localparam logic [3:0] C_ALU_AND  = 4'd2;
  localparam logic [3:0] C_ALU_OR   = 4'd3;
  localparam logic [3:0] C_ALU_SLT  = 4'd4;
  localparam logic [3:0] C_ALU_SLTU = 4'd5;
  localparam logic [3:0] C_ALU_PASS = 4'd6;
  localparam logic [3:0] C_ALU_XOR  = 4'd7;
  localparam logic [3:0] C_ALU_NOR  = 4'd8;

  localparam logic [3:0] C_MD_MULT  = 4'd1;
  localparam logic [3:0] C_MD_MULTU = 4'd2;
  localparam logic [3:0] C_MD_DIV   = 4'd3;
  localparam logic [3:0] C_MD_DIVU  = 4'd4;
  localparam logic [3:0] C_MD_MTHI  = 4'd5;
  localparam logic [3:0] C_MD_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] C_MD_MADD  = 4'd7;
  localparam logic [3:0] C_MD_MADDU = 4'd8;
`endif

  // ---------------- ALU ----------------
  logic [WIDTH:0] w_add_x, w_sub_x;
  logic           w_ov;

  // One extra sign bit lets overflow show up as disagreement of the top two bits.
  assign w_add_x = {sa[WIDTH-1], sa} + {sb[WIDTH-1], sb};
  assign w_sub_x = {sa[WIDTH-1], sa} - {sb[WIDTH-1], sb};

  always_comb begin
    alu_out = '0;
    case (alu_op)
      C_ALU_ADD:  alu_out = w_add_x[WIDTH-1:0];
      C_ALU_SUB:  alu_out = w_sub_x[WIDTH-1:0];
      C_ALU_AND:  alu_out = sa & sb;
      C_ALU_OR:   alu_out = sa | sb;
      C_ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(sa) < $signed(sb))};
      C_ALU_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (sa < sb)};
      C_ALU_PASS: alu_out = sb;
      C_ALU_XOR:  alu_out = sa ^ sb;
      C_ALU_NOR:  alu_out = ~(sa | sb);
      default:    alu_out = '0;
    endcase
  end

  assign w_ov = ov_en &
                (((alu_op == C_ALU_ADD) & (w_add_x[WIDTH] != w_add_x[WIDTH-1])) |
                 ((alu_op == C_ALU_SUB) & (w_sub_x[WIDTH] != w_sub_x[WIDTH-1])));

  always_comb begin
    exc_code = 5'd0;
    if (w_ov & load)       exc_code = 5'd4;
    else if (w_ov & store) exc_code = 5'd5;
    else if (w_ov)         exc_code = 5'd12;
  end

  // ---------------- MDU datapath ----------------
  logic [W2-1:0]    w_prod_s, w_prod_u;
  logic [WIDTH-1:0] w_one, w_div_b, w_abs_a, w_abs_b, w_abs_bd;
  logic [WIDTH-1:0] w_uq, w_ur, w_sq_mag, w_sr_mag, w_sq, w_sr;
  logic             w_div0;

  assign w_prod_s = {{WIDTH{sa[WIDTH-1]}}, sa} * {{WIDTH{sb[WIDTH-1]}}, sb};
  assign w_prod_u = {{WIDTH{1'b0}}, sa} * {{WIDTH{1'b0}}, sb};

  // A zero divisor is replaced by one so the dividers never see /0; results are discarded.
  assign w_one    = {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_div0   = (sb == '0);
  assign w_div_b  = w_div0 ? w_one : sb;
  assign w_uq     = sa / w_div_b;
  assign w_ur     = sa % w_div_b;

  assign w_abs_a  = sa[WIDTH-1] ? -sa : sa;
  assign w_abs_b  = sb[WIDTH-1] ? -sb : sb;
  assign w_abs_bd = w_div0 ? w_one : w_abs_b;
  assign w_sq_mag = w_abs_a / w_abs_bd;
  assign w_sr_mag = w_abs_a % w_abs_bd;
  assign w_sq     = (sa[WIDTH-1] ^ sb[WIDTH-1]) ? -w_sq_mag : w_sq_mag;
  assign w_sr     = sa[WIDTH-1] ? -w_sr_mag : w_sr_mag;

  // ---------------- MDU sequencing ----------------
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] shi_q, shi_d, slo_q, slo_d;

  assign busy = (cnt_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    shi_d = shi_q;
    slo_d = slo_q;
    if (busy) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        hi_d = shi_q;
        lo_d = slo_q;
      end
    end else if (md_start & ~req) begin
      case (md_op)
        C_MD_MULT: begin
          {shi_d, slo_d} = w_prod_s;
          cnt_d          = C_MULT_N;
        end
        C_MD_MULTU: begin
          {shi_d, slo_d} = w_prod_u;
          cnt_d          = C_MULT_N;
        end
        C_MD_DIV: begin
          shi_d = w_div0 ? hi_q : w_sr;
          slo_d = w_div0 ? lo_q : w_sq;
          cnt_d = C_DIV_N;
        end
        C_MD_DIVU: begin
          shi_d = w_div0 ? hi_q : w_ur;
          slo_d = w_div0 ? lo_q : w_uq;
          cnt_d = C_DIV_N;
        end
        C_MD_MTHI: hi_d = sa;
        C_MD_MTLO: lo_d = sa;
`ifdef MDU_MADD_EN
        C_MD_MADD: begin
          {shi_d, slo_d} = {hi_q, lo_q} + w_prod_s;
          cnt_d          = C_MULT_N;
        end
        C_MD_MADDU: begin
          {shi_d, slo_d} = {hi_q, lo_q} + w_prod_u;
          cnt_d          = C_MULT_N;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      shi_q <= '0;
      slo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      shi_q <= shi_d;
      slo_q <= slo_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised EX-stage execute unit: combinational ALU with exception-code generation, plus a multi-cycle multiply/divide unit (MDU) with architectural HI/LO registers.
- Sits in the EX stage of the pipelined MIPS core. ALU result and exception code feed the EX/MEM register.
- The MDU busy flag feeds the hazard unit, which stalls any MD instruction while busy.

Parameters:
- WIDTH, 32: datapath width of sa, sb, alu_out, hi, lo.
- MULT_CYCLES, 5: busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10: busy cycles for div/divu (≥1, ≥MULT_CYCLES).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sa  in  WIDTH  operand A (rs).
- sb  in  WIDTH  operand B (rt or immediate).
- alu_op  in  4  ALU operation select.
- ov_en  in  1  overflow checking enabled (add/addi/sub, and address computation for load/store).
- load  in  1  current instruction is a load.
- store  in  1  current instruction is a store.
- md_op  in  4  MDU operation select.
- md_start  in  1  issue the MDU operation this cycle.
- req  in  1  exception/interrupt flush of the EX instruction.
- alu_out  out  WIDTH  ALU result (combinational).
- exc_code  out  5  ALU exception code (combinational).
- busy  out  1  MDU operation in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- ALU is combinational, with zero latency.
- alu_op encoding:
  - 0000 add; 0001 sub; 0010 and; 0011 or; 0100 slt (signed); 0101 sltu; 0110 pass sb; 0111 xor; 1000 nor.
  - All other codes produce 0.
  - Results are modulo 2^WIDTH. slt/sltu return 1 or 0, zero-extended.
- Overflow (OV) detection:
  - Compute with WIDTH+1-bit sign extension.
  - OV = ov_en & (op is add or sub) & (bit WIDTH != bit WIDTH-1).
- exc_code priority:
  - OV&load → 4 (AdEL).
  - else OV&store → 5 (AdES).
  - else OV → 12 (Ov).
  - else 0.
  - exc_code does not depend on md_op, md_start or busy.
- MDU accept condition: accept = md_start & ~req & ~busy. Ignored starts have no effect.
- md_op encoding:
  - 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi (hi←sa), 0110 mtlo (lo←sa).
  - Other codes are a no-op: no busy, no HI/LO change.
- mthi/mtlo: written at the accepting edge; busy stays 0.
- mult/div sequencing:
  - At the accepting edge, latch the result into internal shadow registers and load the cycle counter with N (MULT_CYCLES or DIV_CYCLES).
  - busy = (counter != 0); it is high for exactly N cycles.
  - Each edge with counter > 0 decrements the counter.
  - On the 1→0 edge, hi/lo take the shadow values, visible in the same cycle busy falls.
- mult/multu: {hi,lo} = full 2·WIDTH-bit signed/unsigned product.
- div/divu:
  - lo = quotient, truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - Signed MIN/−1: lo = MIN, hi = 0.
  - Divide by zero: full DIV_CYCLES busy, hi/lo unchanged.
- req while busy: does not cancel the in-flight operation. req only blocks a new accept.
- Counter width: $clog2(DIV_CYCLES+1).
- Reset:
  - hi=0, lo=0, counter=0, busy=0, shadows=0.
  - A reset mid-operation discards the pending result.
  - Reset has priority over an accept in the same cycle.

Optional Feature:
- MDU_MADD_EN defined: adds md_op 0111 madd and 1000 maddu.
  - Shadow = {hi,lo} + signed/unsigned product, sampled at the accepting edge, modulo 2^(2·WIDTH).
  - MULT_CYCLES latency; same busy/commit rules as mult.
- MDU_MADD_EN undefined: 0111 and 1000 are no-ops (no busy, no HI/LO change).

Test Plan:
- ALU overflow codes (WIDTH=32, ov_en=1, add, sa=0x7FFFFFFF, sb=1):
  - load=0, store=0 → alu_out=0x80000000, exc_code=12.
  - load=1 → exc_code=4; store=1 → exc_code=5.
  - ov_en=0 → exc_code=0.
- slt vs sltu: sa=0xFFFFFFFF, sb=1 → slt gives alu_out=1; sltu gives alu_out=0.
- mult timing: sa=−3, sb=7, mult accepted at edge k.
  - busy=1 for cycles k+1..k+5, then 0.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB appear with busy falling; unchanged before that.
- Signed division: div sa=−7, sb=2 → after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Division edge cases:
  - div sa=0x80000000, sb=−1 → lo=0x80000000, hi=0.
  - divu by 0 with hi=0x11, lo=0x22 → busy for 10 cycles, hi/lo stay 0x11/0x22.
- Ignored starts and reset:
  - md_start with req=1 → no busy, HI/LO unchanged.
  - mtlo(5) while busy → ignored.
  - reset asserted at busy cycle 3 → next cycle busy=0, hi=lo=0, and no later commit.
